// File: rtl/core_pkg.sv
// Shared ISA constants and fetch-stage types for the 3-stage core.
package core_pkg;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  localparam logic [6:0]  OPC_RTYPE = 7'b0110011;
  localparam logic [6:0]  OPC_ITYPE = 7'b0010011;
  localparam logic [6:0]  OPC_JALR  = 7'b1100111;
  localparam logic [6:0]  OPC_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush. The head entry is visible combinationally
// so the fetch stage can present it in the same cycle it becomes valid.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata   = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && full && !do_pop));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, credit-limited memory requests, in-order response
// buffering and redirect handling with squash of stale in-flight fetches.
module fetch_stage
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic [6:0]      if_opcode,
  output logic [2:0]      if_func3,
  output logic [6:0]      if_func7
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   kill_cnt_reg, kill_cnt_next;

  logic [CW-1:0]   out_count, tag_count;
  logic            out_empty, out_full, tag_empty, tag_full;
  logic [XLEN-1:0] tag_head, head_pc;
  logic [31:0]     head_inst;
  logic            pop, req_fire, rsp_keep;
  logic [CW:0]     credit_used;

  assign if_valid = !out_empty && !redirect_valid;
  assign pop      = if_valid && if_ready;

  // Counting this cycle's pop as freed keeps one request in flight per cycle
  // with a 1-cycle memory; the slot is guaranteed empty by the time the
  // response can arrive.
  assign credit_used    = {1'b0, outstanding_reg} + {1'b0, out_count} - (CW+1)'(pop);
  assign imem_req_valid = (state_reg == RUN) && !redirect_valid &&
                          (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect_valid && (kill_cnt_reg == '0);

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    kill_cnt_next    = kill_cnt_reg;
    outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      pc_next       = redirect_pc & ~XLEN'(3);
      kill_cnt_next = outstanding_reg - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_next = pc_reg + XLEN'(4);
      if (imem_rsp_valid && kill_cnt_reg != '0) kill_cnt_next = kill_cnt_reg - CW'(1);
    end
    unique case (state_reg)
      BOOT:    state_next = RUN;
      RUN:     if (redirect_valid && kill_cnt_next != '0) state_next = DRAIN;
      DRAIN:   if (!redirect_valid && kill_cnt_next == '0) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      outstanding_reg <= '0;
      kill_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      outstanding_reg <= outstanding_next;
      kill_cnt_reg    <= kill_cnt_next;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .pop   (rsp_keep),
    .flush (redirect_valid),
    .wdata (pc_reg),
    .rdata (tag_head),
    .count (tag_count),
    .empty (tag_empty),
    .full  (tag_full)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN + 32)) u_out_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({tag_head, imem_rsp_data}),
    .rdata ({head_pc, head_inst}),
    .count (out_count),
    .empty (out_empty),
    .full  (out_full)
  );

  assign if_pc     = out_empty ? '0 : head_pc;
  assign if_inst   = out_empty ? NOP_INST : head_inst;
  assign if_opcode = if_inst[6:0];
  assign if_func3  = if_inst[14:12];
  assign if_func7  = if_inst[31:25];

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding_reg != '0));
  a_tag_present:  assert property (@(posedge clk) disable iff (!rst_n)
    rsp_keep |-> !tag_empty);
  a_tag_bounded:  assert property (@(posedge clk) disable iff (!rst_n)
    (tag_count <= outstanding_reg) && !(req_fire && tag_full));
  a_out_room:     assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_keep && out_full && !pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural memory with selectable latency,
// expected PCs queued by the stimulus and checked by an independent monitor.
module tb_fetch_stage;
  import core_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_inst;
  logic [6:0]  if_opcode, if_func7;
  logic [2:0]  if_func3;

  int          mem_lat = 1;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_opcode      (if_opcode),
    .if_func3       (if_func3),
    .if_func7       (if_func7)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013 ^ {a[7:0], 24'h0};
  endfunction

  // Fixed-latency in-order memory; discards in-flight responses on reset.
  logic [7:0]  pv;
  logic [31:0] pa [8];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < 8; i++) pa[i] <= '0;
    end else begin
      pv    <= {pv[6:0], imem_req_valid && imem_req_ready};
      pa[0] <= imem_req_addr;
      for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
    end
  end
  assign imem_rsp_valid = pv[mem_lat-1];
  assign imem_rsp_data  = mem_word(pa[mem_lat-1]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every decode handshake must match the next queued PC.
  always @(negedge clk) begin
    if (rst_n && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_if: got pc %0h expected no instruction", if_pc);
      end else begin
        logic [31:0] e, w;
        e = exp_q.pop_front();
        w = mem_word(e);
        $display("if handshake pc=%08h inst=%08h", if_pc, if_inst);
        chk("if_pc", if_pc, e);
        chk("if_inst", if_inst, w);
        chk("if_fields", {if_opcode, if_func3, if_func7}, {w[6:0], w[14:12], w[31:25]});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, imem_req_valid, 0);
    chk({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    chk({tag, "_if_valid"}, if_valid, 0);
    chk({tag, "_if_pc"}, if_pc, 0);
    chk({tag, "_if_inst"}, if_inst, NOP_INST);
  endtask

  // Release reset just after an edge; cycle 0 is BOOT.
  task automatic boot_check();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("boot_no_req", imem_req_valid, 0);
    @(negedge clk); chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    @(negedge clk); chk("no_if_valid_c2", if_valid, 0);
    @(negedge clk); chk("first_if_valid_c3", if_valid, 1);
    chk("first_if_pc_c3", if_pc, RESET_PC);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    if_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    #12;
    check_reset_outputs("reset");

    // 1: streaming from reset, one instruction per cycle
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
    boot_check();
    for (int c = 4; c <= 10; c++) begin
      @(negedge clk);
      chk("throughput_if_valid", if_valid, 1);
    end
    step();
    if_ready = 1'b0;

    // 2: decode back-pressure fills the buffer and stops requests
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("stall_req_valid", imem_req_valid, 0);
      chk("stall_if_valid", if_valid, 1);
      chk("stall_if_pc", if_pc, 32'h20);
    end
    step();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h20 + 32'(4 * i));
    if_ready = 1'b1;
    wait_drain("t2_drain", 40);
    if_ready = 1'b0;

    // 3: 3-cycle memory, redirect with two fetches in flight
    idle(12);
    mem_lat = 3;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    chk("redirect_if_valid", if_valid, 0);
    chk("redirect_req_valid", imem_req_valid, 0);
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_req1_valid", imem_req_valid, 1);
    chk("t3_req1_addr", imem_req_addr, 32'h200);
    step();
    @(negedge clk); chk("t3_req2_addr", imem_req_addr, 32'h204);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h100; if_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("drain_req_valid_a", imem_req_valid, 0);
    chk("drain_if_valid_a", if_valid, 0);
    step();
    @(negedge clk);
    chk("drain_req_valid_b", imem_req_valid, 0);
    chk("drain_if_valid_b", if_valid, 0);
    step();
    @(negedge clk);
    chk("t3_resume_valid", imem_req_valid, 1);
    chk("t3_resume_addr", imem_req_addr, 32'h100);
    wait_drain("t3_drain", 60);
    if_ready = 1'b0;

    // 4: memory not ready, address must hold
    idle(12);
    mem_lat = 1;
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8; if_ready = 1'b1;
    exp_q.push_back(32'h8); exp_q.push_back(32'hC); exp_q.push_back(32'h10);
    step(); redirect_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_req_valid", imem_req_valid, 1);
      chk("hold_req_addr", imem_req_addr, 32'h8);
      step();
    end
    imem_req_ready = 1'b1;
    wait_drain("t4_drain", 40);
    if_ready = 1'b0;

    // 5: unaligned target; redirect coincides with a response and if_ready
    idle(12);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(); redirect_valid = 1'b0;
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h102; if_ready = 1'b1;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    @(negedge clk);
    chk("t5_if_valid_forced", if_valid, 0);
    chk("t5_req_blocked", imem_req_valid, 0);
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_req_valid", imem_req_valid, 1);
    chk("t5_aligned_addr", imem_req_addr, 32'h100);
    wait_drain("t5_drain", 40);
    if_ready = 1'b0;

    // 6: asynchronous reset mid-stream
    idle(4);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step(); redirect_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("pre_reset_if_pc", if_pc, 32'h300);
    step();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) exp_q.push_back(RESET_PC + 32'(4 * i));
    if_ready = 1'b1;
    boot_check();
    wait_drain("t6_drain", 40);
    if_ready = 1'b0;

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
